led_blink_scheduler: RTL and testbench
======================================

# led_blink_scheduler

Shares the single board LED between four requesters, each asking for a burst of 1 to 16 blinks. The block arbitrates round-robin, times each on/off phase with an internal countdown, and inserts a dark gap between bursts so that consecutive owners stay visually distinct. It sits between status-reporting logic (e.g. button/FSM debug sources) and the LED pin on the Spartan-3E board, replacing free-running single-source blinkers.

## Interface
- HALF_PERIOD_CYCLES, 50_000_000, clk cycles per LED on-phase, off-phase and inter-burst gap (1 s at 50 MHz); legal range 2 to 2^26-1.
- clk  in  1  system clock, 50 MHz on board
- rst_n  in  1  asynchronous, active-low reset
- req  in  4  level request per requester, bit i = requester i
- req_count  in  16  blink count per requester, packed as bits [4i+3:4i]; value 0 means 16 blinks
- grant  out  4  one-hot owner of the LED; all-zero when no burst is active
- done  out  4  one-cycle pulse on bit i when requester i's burst completes normally
- ledpin  out  1  LED drive, 1 = lit
- busy  out  1  high in any state other than IDLE

## Operation
- Reset (async, rst_n=0): state IDLE, grant=0, done=0, ledpin=0, busy=0, rr pointer=0, timer=0, remaining=0.
- States: IDLE, ON, OFF, GAP.
- IDLE: if any req bit is set, select the first set bit scanning from pointer upward and wrapping modulo 4. Register grant=onehot(winner), latch remaining=req_count field of the winner (0 maps to 16, held in 5 bits), set timer=HALF_PERIOD_CYCLES-1, ledpin=1, go to ON, pointer=winner+1 mod 4.
- ON: timer decrements each cycle. At timer==0: ledpin=0, timer reload, go to OFF.
- OFF: timer decrements each cycle. At timer==0: if remaining==1, then grant=0, done[winner]=1 for one cycle, timer reload, go to GAP; otherwise remaining-1, ledpin=1, timer reload, go to ON.
- GAP: ledpin=0, grant=0. At timer==0, go to IDLE. Arbitration happens only in IDLE, never in GAP.
- Abort: if req[owner] drops while in ON or OFF, the next edge forces ledpin=0 and grant=0, reloads the timer and enters GAP. No done pulse is issued for an aborted burst.
- req_count is sampled only at grant. Changes mid-burst are ignored.
- req bits of non-owners are ignored during a burst. They are not latched; a requester must hold req until granted.
- Timer width is clog2(HALF_PERIOD_CYCLES). remaining is 5 bits. There is no other arithmetic.

## Timing
- req rising in IDLE leads to grant and ledpin high on the next clk edge, which is 1 cycle of latency.
- Each on-phase, off-phase and gap lasts exactly HALF_PERIOD_CYCLES cycles.
- grant stays high for exactly 2*HALF_PERIOD_CYCLES*N cycles, where N is the effective count.
- done is high in the first cycle that grant is low, which is also the first GAP cycle.
- From one grant falling to the next possible grant rising: HALF_PERIOD_CYCLES+1 cycles (GAP plus one IDLE cycle).
- busy=0 only in IDLE. It is low for at least 1 cycle between bursts.
- When an abort and the final OFF timer expiry occur in the same cycle, the abort wins and no done pulse is issued.
- Asserting rst_n=0 mid-burst clears all outputs immediately without waiting for a clk edge. After rst_n rises, the pointer restarts at requester 0.

## Test plan
- HALF_PERIOD_CYCLES=4, req=0001, req_count[3:0]=3: grant=0001 one cycle after req. ledpin pattern is 4 on / 4 off ×3. Grant lasts 24 cycles, done=0001 pulses once, then a 4-cycle gap and busy falls.
- req_count=0 for requester 2 with HALF_PERIOD_CYCLES=4: exactly 16 blinks, grant=0100 for 128 cycles, single done pulse.
- req=1111 held, all counts=1: grants occur in order 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by 4 gap cycles plus 1 idle cycle.
- Requester 1 granted with count 5, req[1] dropped during the 2nd ON phase: ledpin=0 and grant=0 next cycle, done stays 0, a 4-cycle GAP follows, then a pending req[3] is granted.
- Drop req[0] in the exact cycle the final OFF timer reaches 0: no done pulse, GAP is entered.
- Assert rst_n=0 asynchronously mid-ON: ledpin, grant, done and busy go to 0 before the next clk edge. After release with req=1111, the first grant is 0001.

Source files
------------

// File: rtl/led_blink_scheduler.sv
// Round-robin owner of the single board LED: each granted requester gets a burst
// of 1..16 on/off blinks, followed by a dark gap before the next owner is chosen.
module led_blink_scheduler #(
  parameter int HALF_PERIOD_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] req_count,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        ledpin,
  output logic        busy
);

  localparam int TIMER_W = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(HALF_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [4:0]         remaining, remaining_nxt;
  logic [1:0]         ptr, ptr_nxt;
  logic [1:0]         owner, owner_nxt;
  logic [3:0]         grant_nxt, done_nxt;
  logic               ledpin_nxt;
  logic [1:0]         winner;
  logic               abort;

  // First set request at or after the pointer, wrapping modulo 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = p;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  function automatic logic [4:0] burst_len(input logic [3:0] c);
    return (c == 4'd0) ? 5'd16 : {1'b0, c};
  endfunction

  assign winner = pick(req, ptr);
  assign abort  = !req[owner];
  assign busy   = (state != IDLE);

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    remaining_nxt = remaining;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    grant_nxt     = grant;
    done_nxt      = 4'b0000;
    ledpin_nxt    = ledpin;
    unique case (state)
      IDLE: begin
        if (|req) begin
          owner_nxt     = winner;
          grant_nxt     = 4'b0001 << winner;
          remaining_nxt = burst_len(req_count[{winner, 2'b00} +: 4]);
          timer_nxt     = RELOAD;
          ledpin_nxt    = 1'b1;
          ptr_nxt       = winner + 2'd1;
          state_nxt     = ON;
        end
      end
      ON: begin
        // Abort outranks timer expiry in both lit and dark phases.
        if (abort) begin
          ledpin_nxt = 1'b0;
          grant_nxt  = 4'b0000;
          timer_nxt  = RELOAD;
          state_nxt  = GAP;
        end else if (timer == '0) begin
          ledpin_nxt = 1'b0;
          timer_nxt  = RELOAD;
          state_nxt  = OFF;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      OFF: begin
        if (abort) begin
          ledpin_nxt = 1'b0;
          grant_nxt  = 4'b0000;
          timer_nxt  = RELOAD;
          state_nxt  = GAP;
        end else if (timer == '0) begin
          timer_nxt = RELOAD;
          if (remaining == 5'd1) begin
            grant_nxt = 4'b0000;
            done_nxt  = grant;
            state_nxt = GAP;
          end else begin
            remaining_nxt = remaining - 5'd1;
            ledpin_nxt    = 1'b1;
            state_nxt     = ON;
          end
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      GAP: begin
        ledpin_nxt = 1'b0;
        grant_nxt  = 4'b0000;
        if (timer == '0) state_nxt = IDLE;
        else             timer_nxt = timer - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= 5'd0;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      grant     <= 4'b0000;
      done      <= 4'b0000;
      ledpin    <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      remaining <= remaining_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      grant     <= grant_nxt;
      done      <= done_nxt;
      ledpin    <= ledpin_nxt;
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler with a 4-cycle half period; expected
// values are hand-derived cycle counts and grant orders.
module tb_led_blink_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_count;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        ledpin;
  logic        busy;

  int total = 0;
  int bad   = 0;

  led_blink_scheduler #(.HALF_PERIOD_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_count (req_count),
    .grant     (grant),
    .done      (done),
    .ledpin    (ledpin),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick(1);
    chk("idle_wait", busy, 0);
  endtask

  initial begin
    logic [3:0] g;
    int gcnt, dcnt, blinks;
    logic prev_led;

    rst_n = 1'b0;
    req = 4'b0000;
    req_count = 16'h0000;
    #12;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_led", ledpin, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(1);

    // Requester 0, three blinks.
    req = 4'b0001; req_count = 16'h0003;
    tick(1);
    chk("t1_busy", busy, 1);
    for (int c = 0; c < 24; c++) begin
      chk("t1_led", ledpin, ((c % 8) < 4) ? 1 : 0);
      chk("t1_grant", grant, 4'b0001);
      chk("t1_done_lo", done, 0);
      tick(1);
    end
    chk("t1_grant_end", grant, 0);
    chk("t1_done", done, 4'b0001);
    chk("t1_led_gap", ledpin, 0);
    req = 4'b0000;
    tick(1);
    chk("t1_done_pulse", done, 0);
    tick(2);
    chk("t1_gap_busy", busy, 1);
    tick(1);
    chk("t1_idle", busy, 0);

    // Requester 2, count 0 means 16 blinks.
    req = 4'b0100; req_count = 16'h0000;
    gcnt = 0; dcnt = 0; blinks = 0; prev_led = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (grant == 4'b0100) gcnt++;
      if (done != 4'b0000) begin
        dcnt++;
        req = 4'b0000;
      end
      if (ledpin && !prev_led) blinks++;
      prev_led = ledpin;
      if (!busy) break;
    end
    chk("t2_grant_cycles", gcnt, 128);
    chk("t2_done_pulses", dcnt, 1);
    chk("t2_blinks", blinks, 16);
    chk("t2_idle", busy, 0);

    // Async reset mid-ON, then round robin from requester 0.
    req = 4'b0001; req_count = 16'h0003;
    tick(1);
    chk("t6_grant", grant, 4'b0001);
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_led", ledpin, 0);
    chk("t6_async_done", done, 0);
    chk("t6_async_busy", busy, 0);
    req = 4'b1111; req_count = 16'h1111;
    #2 rst_n = 1'b1;
    tick(1);
    g = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", grant, g);
      tick(7);
      chk("t3_grant_hold", grant, g);
      tick(1);
      chk("t3_grant_off", grant, 0);
      chk("t3_done", done, g);
      tick(4);
      chk("t3_idle_gap", busy, 0);
      tick(1);
      g = {g[2:0], g[3]};
    end
    chk("t3_wrap", grant, 4'b0001);
    req = 4'b0000;
    wait_idle();

    // Abort of requester 1 in its second ON phase; requester 3 waits.
    req = 4'b1010; req_count = 16'h0050;
    tick(1);
    chk("t4_grant", grant, 4'b0010);
    tick(9);
    chk("t4_led_on2", ledpin, 1);
    req = 4'b1000;
    tick(1);
    chk("t4_abort_grant", grant, 0);
    chk("t4_abort_led", ledpin, 0);
    chk("t4_abort_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_no_done", done, 0);
      tick(1);
    end
    chk("t4_idle", busy, 0);
    tick(1);
    chk("t4_next_grant", grant, 4'b1000);
    req = 4'b0000;
    wait_idle();

    // Abort coinciding with the final OFF expiry.
    req = 4'b0001; req_count = 16'h0001;
    tick(1);
    chk("t5_grant", grant, 4'b0001);
    tick(7);
    chk("t5_grant_last", grant, 4'b0001);
    req = 4'b0000;
    tick(1);
    chk("t5_done", done, 0);
    chk("t5_grant_off", grant, 0);
    chk("t5_gap_busy", busy, 1);
    tick(4);
    chk("t5_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
